sd_fifo_param: RTL and testbench

Parametrised successor to the SD data-path FIFO, sitting between the SD card data engine and the bus/DMA side. It gives width, depth and watermark control, protected overrun/underrun, which discards illegal accesses instead of corrupting state, and a high-water statistic for tuning SD transfer burst sizes. Storage is first-word-fall-through with an asynchronous-read memory.

---
 rtl/sd_fifo_param_if.sv | 39 +++
 rtl/sd_fifo_param.sv | 74 +++++++
 tb/tb_sd_fifo_param.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sd_fifo_param_if.sv
// Handshake, data and status bundle between the SD data engine side and the
// bus/DMA side of sd_fifo_param.
interface sd_fifo_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
);
    logic                  i_fifo_flush;
    logic                  i_fifo_push;
    logic                  i_fifo_pop;
    logic [DATA_WIDTH-1:0] i_fifo_data;
    logic [DATA_WIDTH-1:0] o_fifo_data;
    logic                  o_fifo_empty;
    logic                  o_fifo_full;
    logic [ADDR_WIDTH:0]   o_fifo_items;
    logic [ADDR_WIDTH:0]   i_almost_full_level;
    logic [ADDR_WIDTH:0]   i_almost_empty_level;
    logic                  o_fifo_almost_full;
    logic                  o_fifo_almost_empty;
    logic                  o_fifo_overrun;
    logic                  o_fifo_underrun;
    logic                  i_high_water_clear;
    logic [ADDR_WIDTH:0]   o_fifo_high_water;

    modport master (
        output i_fifo_flush, i_fifo_push, i_fifo_pop, i_fifo_data,
        output i_almost_full_level, i_almost_empty_level, i_high_water_clear,
        input  o_fifo_data, o_fifo_empty, o_fifo_full, o_fifo_items,
        input  o_fifo_almost_full, o_fifo_almost_empty,
        input  o_fifo_overrun, o_fifo_underrun, o_fifo_high_water
    );

    modport slave (
        input  i_fifo_flush, i_fifo_push, i_fifo_pop, i_fifo_data,
        input  i_almost_full_level, i_almost_empty_level, i_high_water_clear,
        output o_fifo_data, o_fifo_empty, o_fifo_full, o_fifo_items,
        output o_fifo_almost_full, o_fifo_almost_empty,
        output o_fifo_overrun, o_fifo_underrun, o_fifo_high_water
    );
endinterface

// File: rtl/sd_fifo_param.sv
// Parametrised first-word-fall-through FIFO for the SD data path with
// watermarks, protected overrun/underrun and a high-water statistic.
module sd_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic           i_clk,
    input  logic           i_reset,
    sd_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wrptr;
    logic [ADDR_WIDTH:0]   rdptr;
    logic [ADDR_WIDTH:0]   wrptr_next;
    logic [ADDR_WIDTH:0]   rdptr_next;
    logic [ADDR_WIDTH:0]   items;
    logic [ADDR_WIDTH:0]   items_next;
    logic [ADDR_WIDTH:0]   high_water;
    logic                  overrun;
    logic                  underrun;
    logic                  empty;
    logic                  full;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty = (wrptr == rdptr);
    assign full  = (wrptr[ADDR_WIDTH] != rdptr[ADDR_WIDTH]) &&
                   (wrptr[ADDR_WIDTH-1:0] == rdptr[ADDR_WIDTH-1:0]);
    assign items = wrptr - rdptr;

    // A full FIFO still takes a push when a pop frees the head slot this cycle.
    assign pop_ok  = bus.i_fifo_pop && !empty && !bus.i_fifo_flush;
    assign push_ok = bus.i_fifo_push && (!full || pop_ok) && !bus.i_fifo_flush;

    assign wrptr_next = wrptr + {{ADDR_WIDTH{1'b0}}, push_ok};
    assign rdptr_next = rdptr + {{ADDR_WIDTH{1'b0}}, pop_ok};
    assign items_next = wrptr_next - rdptr_next;

    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_fifo_flush) begin
            wrptr      <= '0;
            rdptr      <= '0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
            high_water <= '0;
        end else begin
            wrptr <= wrptr_next;
            rdptr <= rdptr_next;
            if (bus.i_fifo_push && !push_ok)
                overrun <= 1'b1;
            if (bus.i_fifo_pop && !pop_ok)
                underrun <= 1'b1;
            if (bus.i_high_water_clear || (items_next > high_water))
                high_water <= items_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok && !i_reset)
            mem[wrptr[ADDR_WIDTH-1:0]] <= bus.i_fifo_data;
    end

    assign bus.o_fifo_data         = mem[rdptr[ADDR_WIDTH-1:0]];
    assign bus.o_fifo_empty        = empty;
    assign bus.o_fifo_full         = full;
    assign bus.o_fifo_items        = items;
    assign bus.o_fifo_almost_full  = (items >= bus.i_almost_full_level);
    assign bus.o_fifo_almost_empty = (items <= bus.i_almost_empty_level);
    assign bus.o_fifo_overrun      = overrun;
    assign bus.o_fifo_underrun     = underrun;
    assign bus.o_fifo_high_water   = high_water;
endmodule

// File: tb/tb_sd_fifo_param.sv
// Directed bench for sd_fifo_param (depth 8) with a queue scoreboard and a
// small reference model of count, sticky flags and high-water.
module tb_sd_fifo_param;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sd_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    logic [DW-1:0] q[$];
    int  m_hw;
    bit  m_ovr;
    bit  m_unr;
    int  checks = 0;
    int  passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        chk("items",        32'(bus.o_fifo_items), 32'(n));
        chk("empty",        32'(bus.o_fifo_empty), 32'(n == 0));
        chk("full",         32'(bus.o_fifo_full), 32'(n == DEPTH));
        chk("almost_full",  32'(bus.o_fifo_almost_full), 32'(n >= int'(bus.i_almost_full_level)));
        chk("almost_empty", 32'(bus.o_fifo_almost_empty), 32'(n <= int'(bus.i_almost_empty_level)));
        chk("overrun",      32'(bus.o_fifo_overrun), 32'(m_ovr));
        chk("underrun",     32'(bus.o_fifo_underrun), 32'(m_unr));
        chk("high_water",   32'(bus.o_fifo_high_water), 32'(m_hw));
        if (n > 0)
            chk("head", bus.o_fifo_data, q[0]);
    endtask

    // One clock of stimulus; the model decides acceptance from the queue depth.
    task automatic cycle(input bit push, input bit pop, input logic [DW-1:0] d,
                         input bit flush = 1'b0, input bit hwclr = 1'b0);
        bit pop_ok;
        bit push_ok;
        @(negedge clk);
        bus.i_fifo_push        = push;
        bus.i_fifo_pop         = pop;
        bus.i_fifo_data        = d;
        bus.i_fifo_flush       = flush;
        bus.i_high_water_clear = hwclr;
        #1;
        if (flush) begin
            q.delete();
            m_ovr = 1'b0;
            m_unr = 1'b0;
            m_hw  = 0;
        end else begin
            pop_ok  = pop && (q.size() > 0);
            push_ok = push && ((q.size() < DEPTH) || pop_ok);
            if (pop_ok) begin
                chk("pop_data", bus.o_fifo_data, q[0]);
                void'(q.pop_front());
            end
            if (push_ok) q.push_back(d);
            if (push && !push_ok) m_ovr = 1'b1;
            if (pop && !pop_ok)   m_unr = 1'b1;
            if (hwclr || (q.size() > m_hw)) m_hw = q.size();
        end
        @(posedge clk);
        #1;
        bus.i_fifo_push        = 1'b0;
        bus.i_fifo_pop         = 1'b0;
        bus.i_fifo_flush       = 1'b0;
        bus.i_high_water_clear = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        m_ovr = 1'b0;
        m_unr = 1'b0;
        m_hw  = 0;
        check_state();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.i_fifo_flush         = 1'b0;
        bus.i_fifo_push          = 1'b0;
        bus.i_fifo_pop           = 1'b0;
        bus.i_fifo_data          = '0;
        bus.i_high_water_clear   = 1'b0;
        bus.i_almost_full_level  = 4'd6;
        bus.i_almost_empty_level = 4'd2;
        m_hw  = 0;
        m_ovr = 1'b0;
        m_unr = 1'b0;

        do_reset();
        // Level 0 forces almost_full even when empty.
        bus.i_almost_full_level = 4'd0;
        #1;
        chk("af_level0", 32'(bus.o_fifo_almost_full), 32'd1);
        bus.i_almost_full_level = 4'd6;

        // Fill and drain.
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'h100 + i);
        for (int i = 0; i < 8; i++) cycle(0, 1, '0);

        // Overrun: the rejected 0xFF must never come out.
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'hA0 + i);
        cycle(1, 0, 32'hFF);
        for (int i = 0; i < 8; i++) cycle(0, 1, '0);
        cycle(0, 0, '0, 1);

        // Push and pop together while full.
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'hC0 + i);
        cycle(1, 1, 32'h55);
        for (int i = 0; i < 8; i++) cycle(0, 1, '0);

        // Push and pop together while empty.
        cycle(1, 1, 32'h77);
        chk("empty_pushpop_data", bus.o_fifo_data, 32'h77);
        cycle(0, 0, '0, 1);

        // Interleaved traffic across several pointer wraps.
        for (int i = 0; i < 80; i++)
            cycle(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), $urandom);
        while (q.size() > 0) cycle(0, 1, '0);
        cycle(0, 0, '0, 1);

        // Flush wins over a simultaneous push.
        for (int i = 0; i < 5; i++) cycle(1, 0, 32'h200 + i);
        cycle(1, 0, 32'h2FF, 1);

        // High-water clear together with a pop loads the post-pop count.
        for (int i = 0; i < 3; i++) cycle(1, 0, 32'h300 + i);
        cycle(0, 1, '0, 0, 1);
        chk("hw_after_clear", 32'(bus.o_fifo_high_water), 32'd2);

        // Reset mid-transfer, then confirm fresh data is presented.
        cycle(1, 0, 32'h400);
        do_reset();
        cycle(1, 0, 32'h401);
        cycle(0, 1, '0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
